debounce_multi: RTL and testbench

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

---
 rtl/debounce_multi.sv | 77 +++++++
 tb/tb_debounce_multi.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: two-flop synchroniser per channel, a tick-qualified
// stability counter, and registered press/release pulses aligned with the db_out change.
module debounce_multi #(
  parameter int CHANNELS = 4,
  parameter int STABLE   = 2048,
  parameter bit INVERT   = 1'b0
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                any_change
);

  localparam int CNT_W = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

  logic [CHANNELS-1:0] level_in;
  logic [CHANNELS-1:0] sync_meta;
  logic [CHANNELS-1:0] sync;
  logic [CHANNELS-1:0] load;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  assign level_in = button_in ^ {CHANNELS{INVERT}};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= level_in;
      sync      <= sync_meta;
    end
  end

  // A channel commits its new level on the qualifying sample that completes the run.
  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = tick && (sync[i] != db_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if ((sync[i] == db_out[i]) || load[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      db_out        <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      any_change    <= 1'b0;
    end else begin
      db_out        <= (db_out & ~load) | (sync & load);
      press_pulse   <= load & sync;
      release_pulse <= load & ~sync;
      any_change    <= |load;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: stimulus pushes expected pulse events with their
// due cycle, a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic          n_reset_inv = 1'b1;
  logic          tick = 1'b1;
  logic [CH-1:0] button = 4'hF;
  logic [CH-1:0] button_inv = 4'hF;

  logic [CH-1:0] db_out, press_pulse, release_pulse;
  logic          any_change;
  logic [CH-1:0] db_inv, press_inv, release_inv;
  logic          any_inv;

  typedef struct {
    int       cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] db;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  debounce_multi #(.CHANNELS(CH), .STABLE(ST), .INVERT(1'b0)) dut (
    .clk(clk), .n_reset(n_reset), .tick(tick), .button_in(button),
    .db_out(db_out), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .any_change(any_change)
  );

  debounce_multi #(.CHANNELS(CH), .STABLE(ST), .INVERT(1'b1)) dut_inv (
    .clk(clk), .n_reset(n_reset_inv), .tick(tick), .button_in(button_inv),
    .db_out(db_inv), .press_pulse(press_inv), .release_pulse(release_inv),
    .any_change(any_inv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int lat, input logic [3:0] press, input logic [3:0] rel,
                          input logic [3:0] db);
    exp_t e;
    e.cyc   = cyc + lat;
    e.press = press;
    e.rel   = rel;
    e.db    = db;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [3:0] btn, input int lat, input logic [3:0] press,
                                input logic [3:0] rel, input logic [3:0] db);
    button = btn;
    if (lat > 0) push_exp(lat, press, rel, db);
  endtask

  // Any pulse or any_change from the main DUT must match the oldest pending expectation.
  always @(negedge clk) begin
    if ((press_pulse !== 4'h0) || (release_pulse !== 4'h0) || (any_change !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_event: press %0h release %0h any %0b, none expected (cycle %0d)",
                 press_pulse, release_pulse, any_change, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("event_cycle", cyc, e.cyc);
        check_output("press_pulse", 32'(press_pulse), 32'(e.press));
        check_output("release_pulse", 32'(release_pulse), 32'(e.rel));
        check_output("db_out", 32'(db_out), 32'(e.db));
        check_output("any_change", 32'(any_change), 32'd1);
        check_output("press_release_overlap", 32'(press_pulse & release_pulse), 32'd0);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rel_cyc;
    #1;
    n_reset = 1'b0;
    n_reset_inv = 1'b0;

    // Reset held with all buttons high: everything stays 0.
    step(3);
    check_output("reset_db", 32'(db_out), 32'd0);
    check_output("reset_press", 32'(press_pulse), 32'd0);
    check_output("reset_release", 32'(release_pulse), 32'd0);
    check_output("reset_any", 32'(any_change), 32'd0);

    n_reset = 1'b1;
    n_reset_inv = 1'b1;
    push_exp(6, 4'hF, 4'h0, 4'hF);
    step(1);
    check_output("post_release_press", 32'(press_pulse), 32'd0);
    check_output("post_release_release", 32'(release_pulse), 32'd0);
    check_output("post_release_any", 32'(any_change), 32'd0);
    step(7);
    check_output("initial_high_db", 32'(db_out), 32'hF);
    apply_stimulus(4'h0, 6, 4'h0, 4'hF, 4'h0);
    step(8);

    // Single channel press, full latency of STABLE+2.
    apply_stimulus(4'b0001, 6, 4'b0001, 4'h0, 4'b0001);
    step(8);
    check_output("ch0_held_db", 32'(db_out), 32'b0001);

    // Three-cycle glitch on channel 1 reaches count STABLE-1 and is rejected.
    apply_stimulus(4'b0011, 0, 4'h0, 4'h0, 4'h0);
    step(3);
    apply_stimulus(4'b0001, 0, 4'h0, 4'h0, 4'h0);
    step(8);
    check_output("glitch_db", 32'(db_out), 32'b0001);
    apply_stimulus(4'b0011, 6, 4'b0010, 4'h0, 4'b0011);
    step(10);
    apply_stimulus(4'b0001, 6, 4'h0, 4'b0010, 4'b0001);
    step(8);

    // Release channel 0, then press again with tick high one cycle in four.
    apply_stimulus(4'b0000, 6, 4'h0, 4'b0001, 4'h0);
    step(8);
    apply_stimulus(4'b0001, 16, 4'b0001, 4'h0, 4'b0001);
    for (int k = 0; k < 20; k++) begin
      tick = ((k % 4) == 3);
      if (k == 12) check_output("tick_hold_e12", 32'(db_out), 32'd0);
      if (k == 15) check_output("tick_hold_e15", 32'(db_out), 32'd0);
      if (k == 16) check_output("tick_commit_e16", 32'(db_out), 32'b0001);
      step(1);
    end
    tick = 1'b1;

    // Simultaneous release on one channel and press on another.
    apply_stimulus(4'b0100, 6, 4'b0100, 4'b0001, 4'b0100);
    step(8);
    apply_stimulus(4'b1000, 6, 4'b1000, 4'b0100, 4'b1000);
    step(8);
    apply_stimulus(4'b0000, 6, 4'h0, 4'b1000, 4'h0);
    step(8);

    // Active-low instance: establish a level, then reset mid-count.
    button_inv = 4'b1110;
    step(7);
    check_output("inv_db_ch0", 32'(db_inv), 32'b0001);
    button_inv = 4'b1100;
    step(4);
    #2;
    n_reset_inv = 1'b0;
    #1;
    check_output("inv_async_db", 32'(db_inv), 32'd0);
    check_output("inv_async_press", 32'(press_inv), 32'd0);
    check_output("inv_async_release", 32'(release_inv), 32'd0);
    check_output("inv_async_any", 32'(any_inv), 32'd0);
    step(2);
    n_reset_inv = 1'b1;
    rel_cyc = cyc;
    step(4);
    check_output("inv_restart_e4", 32'(db_inv), 32'd0);
    step(1);
    check_output("inv_restart_e5", 32'(db_inv), 32'd0);
    step(1);
    check_output("inv_restart_cycle", cyc, rel_cyc + 6);
    check_output("inv_restart_db", 32'(db_inv), 32'b0011);
    check_output("inv_restart_press", 32'(press_inv), 32'b0011);
    check_output("inv_restart_any", 32'(any_inv), 32'd1);
    step(2);

    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
